// File: rtl/line_memory_controller.sv
// line_memory_controller: serves 256-bit cache-line reads and writes from the CPU
// memory port as 8-word bursts on a synchronous single-port 32-bit SRAM.
// Optional build macro LINE_MEM_CTRL_STATS_EN adds per-type request counters.
module line_memory_controller #(
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_mem_read,
    input  logic                       i_mem_write,
    input  logic [31:0]                i_mem_address,
    inout  wire  [255:0]               io_mem_data,
    output logic                       o_mem_ready,
    output logic                       o_mem_done,
    output logic [SRAM_ADDR_WIDTH-1:0] o_sram_address,
    output logic                       o_sram_read_en,
    output logic                       o_sram_write_en,
    output logic [31:0]                o_sram_wdata,
    input  logic [31:0]                i_sram_rdata
`ifdef LINE_MEM_CTRL_STATS_EN
    ,
    output logic [31:0]                o_stat_reads,
    output logic [31:0]                o_stat_writes
`endif
);

    localparam int LINE_W = SRAM_ADDR_WIDTH - 3;
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_BURST,
        RD_DRAIN,
        RESPOND
    } state_t;

    state_t                  state;
    logic [LINE_W-1:0]       line_index;
    logic [255:0]            line_buf;
    logic [2:0]              word_count;
    logic [2:0]              next_word;
    logic [2:0]              drain_count;
    logic                    is_read;
    logic                    drive_bus;
    logic [READ_LATENCY-1:0] cap_valid;
    logic [2:0]              cap_word [READ_LATENCY];
    logic                    unused_addr_bits;

    // Address bits above the SRAM line range and the in-line byte offset are don't-care.
    assign unused_addr_bits = ^{i_mem_address[31:LINE_W+5], i_mem_address[4:0]};

    assign next_word = word_count + 3'd1;

    // The line bus is only ever driven by us during the response cycle of a read.
    assign io_mem_data = drive_bus ? line_buf : 'z;

    // Request sequencer: accepts a line request in IDLE, bursts 8 words, then pulses done.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            o_mem_ready     <= 1'b1;
            o_mem_done      <= 1'b0;
            o_sram_read_en  <= 1'b0;
            o_sram_write_en <= 1'b0;
            o_sram_address  <= '0;
            o_sram_wdata    <= '0;
            drive_bus       <= 1'b0;
            word_count      <= 3'd0;
            drain_count     <= 3'd0;
            line_index      <= '0;
            line_buf        <= '0;
            is_read         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mem_write) begin
                        line_index      <= i_mem_address[LINE_W+4:5];
                        line_buf        <= io_mem_data;
                        is_read         <= 1'b0;
                        o_mem_ready     <= 1'b0;
                        word_count      <= 3'd0;
                        o_sram_write_en <= 1'b1;
                        o_sram_address  <= {i_mem_address[LINE_W+4:5], 3'd0};
                        o_sram_wdata    <= io_mem_data[31:0];
                        state           <= WR_BURST;
                    end else if (i_mem_read) begin
                        line_index      <= i_mem_address[LINE_W+4:5];
                        is_read         <= 1'b1;
                        o_mem_ready     <= 1'b0;
                        word_count      <= 3'd0;
                        o_sram_read_en  <= 1'b1;
                        o_sram_address  <= {i_mem_address[LINE_W+4:5], 3'd0};
                        state           <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (word_count == 3'd7) begin
                        o_sram_write_en <= 1'b0;
                        word_count      <= 3'd0;
                        o_mem_done      <= 1'b1;
                        state           <= RESPOND;
                    end else begin
                        word_count     <= next_word;
                        o_sram_address <= {line_index, next_word};
                        o_sram_wdata   <= line_buf[{next_word, 5'd0} +: 32];
                    end
                end
                RD_BURST: begin
                    if (word_count == 3'd7) begin
                        o_sram_read_en <= 1'b0;
                        word_count     <= 3'd0;
                        drain_count    <= 3'd0;
                        state          <= RD_DRAIN;
                    end else begin
                        word_count     <= next_word;
                        o_sram_address <= {line_index, next_word};
                    end
                end
                RD_DRAIN: begin
                    if (drain_count == DRAIN_LAST) begin
                        o_mem_done <= 1'b1;
                        drive_bus  <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        drain_count <= drain_count + 3'd1;
                    end
                end
                RESPOND: begin
                    o_mem_done  <= 1'b0;
                    drive_bus   <= 1'b0;
                    o_mem_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (cap_valid[READ_LATENCY-1]) begin
                line_buf[{cap_word[READ_LATENCY-1], 5'd0} +: 32] <= i_sram_rdata;
            end
        end
    end

    // Delay line that tags each read strobe with its word slot until the SRAM data arrives.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cap_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                cap_word[i] <= 3'd0;
            end
        end else begin
            cap_valid[0] <= o_sram_read_en;
            cap_word[0]  <= word_count;
            for (int i = 1; i < READ_LATENCY; i++) begin
                cap_valid[i] <= cap_valid[i-1];
                cap_word[i]  <= cap_word[i-1];
            end
        end
    end

`ifdef LINE_MEM_CTRL_STATS_EN
    // Completed-request counters, bumped once per response and free-running on wrap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_stat_reads  <= 32'd0;
            o_stat_writes <= 32'd0;
        end else if (state == RESPOND) begin
            if (is_read) begin
                o_stat_reads <= o_stat_reads + 32'd1;
            end else begin
                o_stat_writes <= o_stat_writes + 32'd1;
            end
        end
    end
`endif

endmodule
